// File: rtl/mod_copy_pkg.sv
// Shared definitions for the FIFO-to-FIFO copy engine: FSM encoding,
// transform op codes and default widths.
package mod_copy_pkg;

    localparam int DW_DEF = 64;
    localparam int CW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CSUM = 2'd2,
        ST_END  = 2'd3
    } state_t;

    localparam logic [1:0] OP_COPY  = 2'b00;
    localparam logic [1:0] OP_INV   = 2'b01;
    localparam logic [1:0] OP_BSWAP = 2'b10;
    localparam logic [1:0] OP_COPY3 = 2'b11;

endpackage

// File: rtl/mod_copy_xform.sv
// Combinational word transform: copy, bitwise invert, or byte reversal of
// the low 64 bits (DW is expected to be at least 64).
module mod_copy_xform
    import mod_copy_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [1:0]    op,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    always_comb begin
        dout = din;
        case (op)
            OP_INV: dout = ~din;
            OP_BSWAP: begin
                for (int i = 0; i < 8; i++) begin
                    dout[8*i +: 8] = din[8*(7-i) +: 8];
                end
            end
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/mod_copy.sv
// Copy engine: streams one job from a source FIFO to a destination FIFO,
// transforming each word and optionally appending an XOR checksum word.
module mod_copy
    import mod_copy_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          m_reset0,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic          csum_en,
    output logic          m_src_getn0,
    input  logic [DW-1:0] m_src0,
    input  logic          m_src_last0,
    input  logic          m_src_almost_empty0,
    input  logic          m_src_empty0,
    output logic          m_dst_putn0,
    output logic [DW-1:0] m_dst0,
    output logic          m_dst_last0,
    input  logic          m_dst_almost_full0,
    input  logic          m_dst_full0,
    output logic          m_endn0,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] wcnt,
    output logic [DW-1:0] csum,
    output state_t        dbg_state
);

    // Handshake: source data is valid the cycle after getn is low (rd_vld);
    // every cycle with putn low transfers exactly one destination word.
    state_t        state, state_nxt;
    logic          rd_vld;
    logic [1:0]    op_q;
    logic          csum_en_q;
    logic [CW-1:0] wcnt_q;
    logic [DW-1:0] csum_q;
    logic [DW-1:0] xf;
    logic          rd_req, wr_data, wr_csum;

    mod_copy_xform #(.DW(DW)) u_xform (
        .op  (op_q),
        .din (m_src0),
        .dout(xf)
    );

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        wr_data   = 1'b0;
        wr_csum   = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                // Arrival of the last word blocks further reads, so the next
                // job's words stay in the source FIFO.
                rd_req  = !m_src_empty0 && !m_dst_almost_full0 &&
                          (!rd_vld || !m_src_almost_empty0) &&
                          !(rd_vld && m_src_last0);
                wr_data = rd_vld;
                if (rd_vld && m_src_last0) state_nxt = csum_en_q ? ST_CSUM : ST_END;
            end
            ST_CSUM: begin
                if (!m_dst_full0) begin
                    wr_csum   = 1'b1;
                    state_nxt = ST_END;
                end
            end
            ST_END: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (m_reset0) begin
            state_nxt = ST_IDLE;
            rd_req    = 1'b0;
            wr_data   = 1'b0;
            wr_csum   = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            rd_vld    <= 1'b0;
            op_q      <= 2'b00;
            csum_en_q <= 1'b0;
            wcnt_q    <= '0;
            csum_q    <= '0;
        end else begin
            state  <= state_nxt;
            rd_vld <= rd_req;
            if (state == ST_IDLE && start && !m_reset0) begin
                op_q      <= op;
                csum_en_q <= csum_en;
                wcnt_q    <= '0;
                csum_q    <= '0;
            end else if (wr_data) begin
                wcnt_q <= wcnt_q + CW'(1);
                csum_q <= csum_q ^ xf;
            end
        end
    end

    assign m_src_getn0 = !rd_req;
    assign m_dst_putn0 = !(wr_data || wr_csum);
    assign m_dst0      = wr_csum ? csum_q : (wr_data ? xf : '0);
    assign m_dst_last0 = wr_csum || (wr_data && m_src_last0 && !csum_en_q);
    assign m_endn0     = !(state == ST_END && !m_reset0);
    assign done        = (state == ST_END) && !m_reset0;
    assign busy        = (state != ST_IDLE);
    assign wcnt        = wcnt_q;
    assign csum        = csum_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_mod_copy.sv
// Bench for mod_copy: queue-based source/destination FIFO models and a
// job-level reference model feeding an expected-output scoreboard.
module tb_mod_copy;
    import mod_copy_pkg::*;

    localparam int DW = 64;
    localparam int CW = 16;
    localparam int DST_DEPTH = 4;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          m_reset0 = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic          csum_en = 1'b0;
    logic          m_src_getn0;
    logic [DW-1:0] m_src0 = '0;
    logic          m_src_last0 = 1'b0;
    logic          m_src_almost_empty0 = 1'b1;
    logic          m_src_empty0 = 1'b1;
    logic          m_dst_putn0;
    logic [DW-1:0] m_dst0;
    logic          m_dst_last0;
    logic          m_dst_almost_full0 = 1'b0;
    logic          m_dst_full0 = 1'b0;
    logic          m_endn0;
    logic          busy;
    logic          done;
    logic [CW-1:0] wcnt;
    logic [DW-1:0] csum;
    state_t        dbg_state;

    mod_copy #(.DW(DW), .CW(CW)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .m_reset0(m_reset0),
        .start(start), .op(op), .csum_en(csum_en),
        .m_src_getn0(m_src_getn0), .m_src0(m_src0), .m_src_last0(m_src_last0),
        .m_src_almost_empty0(m_src_almost_empty0), .m_src_empty0(m_src_empty0),
        .m_dst_putn0(m_dst_putn0), .m_dst0(m_dst0), .m_dst_last0(m_dst_last0),
        .m_dst_almost_full0(m_dst_almost_full0), .m_dst_full0(m_dst_full0),
        .m_endn0(m_endn0), .busy(busy), .done(done), .wcnt(wcnt), .csum(csum),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 wb_clk_i = ~wb_clk_i;

    // ---------------- models and scoreboard ----------------
    logic [DW:0]   src_q[$];   // {last, data}
    logic [DW:0]   exp_q[$];   // {last, data}
    logic [DW-1:0] job_w[$];
    logic [DW:0]   pend;
    logic          pend_v = 1'b0;
    int            dcount = 0;
    bit            drain_rand = 0;
    bit            af_force = 0;
    int            checks = 0, errors = 0, cyc = 0;
    int            put_cnt, rd_cnt, endn_cnt, done_cnt, last_cnt;
    int            first_put_cyc, last_put_cyc, endn_cyc;
    logic [DW-1:0] last_dst;
    logic          last_put_last, last_get;
    logic [CW-1:0] exp_wcnt = '0;
    logic [DW-1:0] exp_csum = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_xf(input logic [1:0] o, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        case (o)
            2'b01:   r = ~d;
            2'b10:   r = {<<8{d}};
            default: r = d;
        endcase
        return r;
    endfunction

    task automatic refresh_flags();
        m_src_empty0        = (src_q.size() == 0);
        m_src_almost_empty0 = (src_q.size() <= 1);
        m_dst_full0         = (dcount >= DST_DEPTH);
        m_dst_almost_full0  = af_force || (dcount >= DST_DEPTH - 1);
    endtask

    task automatic clear_stats();
        put_cnt = 0; rd_cnt = 0; endn_cnt = 0; done_cnt = 0; last_cnt = 0;
        first_put_cyc = -1; last_put_cyc = -1; endn_cyc = -1;
        last_dst = '0; last_put_last = 1'b0; last_get = 1'b0;
        dcount = 0;
        refresh_flags();
    endtask

    // One clock: observe at negedge, update FIFO models, drive after posedge.
    task automatic tick();
        logic [DW:0] e;
        @(negedge wb_clk_i);
        last_get = !m_src_getn0;
        if (!m_dst_putn0) begin
            check("no_write_when_full", m_dst_full0, 1'b0);
            if (exp_q.size() == 0) check("unexpected_put", 1'b1, 1'b0);
            else begin
                e = exp_q.pop_front();
                check("dst_data", m_dst0, e[DW-1:0]);
                check("dst_last", m_dst_last0, e[DW]);
            end
            if (first_put_cyc < 0) first_put_cyc = cyc;
            last_put_cyc = cyc; put_cnt++; dcount++;
            last_dst = m_dst0; last_put_last = m_dst_last0;
            if (m_dst_last0) last_cnt++;
        end
        if (!m_src_getn0) begin
            if (src_q.size() == 0) check("read_when_empty", 1'b1, 1'b0);
            else begin
                pend = src_q.pop_front();
                pend_v = 1'b1;
            end
            rd_cnt++;
        end
        if (!m_endn0) begin endn_cnt++; endn_cyc = cyc; end
        if (done) done_cnt++;
        if (dcount > 0 && (!drain_rand || $urandom_range(0, 1) == 0)) dcount--;
        @(posedge wb_clk_i);
        #1;
        cyc++;
        if (pend_v) begin
            m_src0 = pend[DW-1:0];
            m_src_last0 = pend[DW];
            pend_v = 1'b0;
        end
        refresh_flags();
    endtask

    // Queue job_w as one job in the source FIFO and predict its output.
    task automatic load_job(input logic [1:0] o, input logic ce);
        logic [DW-1:0] x, cs;
        cs = '0;
        for (int i = 0; i < job_w.size(); i++) begin
            src_q.push_back({(i == job_w.size() - 1), job_w[i]});
            x = ref_xf(o, job_w[i]);
            cs ^= x;
            exp_q.push_back({(i == job_w.size() - 1) && !ce, x});
        end
        if (ce) exp_q.push_back({1'b1, cs});
        exp_wcnt = CW'(job_w.size());
        exp_csum = cs;
        refresh_flags();
    endtask

    task automatic launch(input logic [1:0] o, input logic ce);
        clear_stats();
        op = o; csum_en = ce; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input bit rnd_start);
        int k;
        k = 0;
        while (endn_cnt == 0 && k < 300) begin
            tick();
            start = rnd_start && busy && ($urandom_range(0, 3) == 0);
            op = 2'($urandom_range(0, 3));
            csum_en = 1'($urandom_range(0, 1));
            k++;
        end
        start = 1'b0;
        check("job_end_seen", (endn_cnt != 0), 1'b1);
        tick();
    endtask

    task automatic post_checks();
        check("exp_q_drained", exp_q.size(), 0);
        check("wcnt", wcnt, exp_wcnt);
        check("csum", csum, exp_csum);
        check("done_pulses", done_cnt, 1);
        check("endn_pulses", endn_cnt, 1);
        check("busy_after", busy, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n, gets_before;
        logic [DW-1:0] cs;
        clear_stats();
        #12;
        check("rst_getn", m_src_getn0, 1'b1);
        check("rst_putn", m_dst_putn0, 1'b1);
        check("rst_endn", m_endn0, 1'b1);
        check("rst_last", m_dst_last0, 1'b0);
        check("rst_dst", m_dst0, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_wcnt", wcnt, '0);
        check("rst_csum", csum, '0);
        check("rst_state", dbg_state, ST_IDLE);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (2) tick();

        // copy 1..4 with a next-job word queued behind it
        job_w = '{64'd1, 64'd2, 64'd3, 64'd4};
        load_job(2'b00, 1'b0);
        src_q.push_back({1'b0, 64'hdead});
        launch(2'b00, 1'b0);
        wait_end(0);
        post_checks();
        check("copy_puts", put_cnt, 4);
        check("copy_back_to_back", last_put_cyc - first_put_cyc, 3);
        check("copy_endn_after_last", endn_cyc, last_put_cyc + 1);
        check("copy_last_on_4", {last_put_last, last_dst}, {1'b1, 64'd4});
        src_q.delete();

        // invert with checksum: the four inversions cancel in the XOR
        job_w = '{64'd1, 64'd2, 64'd3, 64'd4};
        load_job(2'b01, 1'b1);
        launch(2'b01, 1'b1);
        wait_end(0);
        post_checks();
        check("inv_puts", put_cnt, 5);
        check("inv_csum_word", last_dst, 64'd4);
        check("inv_single_last", last_cnt, 1);

        // destination almost-full stall mid-job
        job_w.delete();
        for (int i = 0; i < 10; i++) job_w.push_back({$urandom, $urandom});
        load_job(2'b10, 1'b0);
        launch(2'b10, 1'b0);
        n = 0;
        while (put_cnt < 3 && n < 50) begin tick(); n++; end
        af_force = 1; refresh_flags();
        gets_before = rd_cnt;
        repeat (3) tick();
        check("af_no_reads", rd_cnt, gets_before);
        af_force = 0; refresh_flags();
        wait_end(0);
        post_checks();
        check("af_puts", put_cnt, 10);

        // two-word job followed by the next job's first word
        job_w = '{64'h11, 64'h22};
        load_job(2'b00, 1'b0);
        src_q.push_back({1'b0, 64'h33});
        launch(2'b00, 1'b0);
        wait_end(0);
        post_checks();
        check("job2_reads", rd_cnt, 2);
        check("job2_leftover", src_q.size(), 1);
        src_q.delete(); refresh_flags();

        // byte swap
        job_w = '{64'h0102030405060708};
        load_job(2'b10, 1'b0);
        launch(2'b10, 1'b0);
        wait_end(0);
        post_checks();
        check("bswap_word", last_dst, 64'h0807060504030201);

        // synchronous clear while a read is in flight
        job_w.delete();
        for (int i = 0; i < 8; i++) job_w.push_back({$urandom, $urandom});
        load_job(2'b01, 1'b0);
        launch(2'b01, 1'b0);
        n = 0;
        while (!(last_get && put_cnt >= 2) && n < 50) begin tick(); n++; end
        check("clr_reached_inflight", last_get, 1'b1);
        m_reset0 = 1'b1;
        #1;
        check("clr_putn", m_dst_putn0, 1'b1);
        check("clr_getn", m_src_getn0, 1'b1);
        check("clr_endn", m_endn0, 1'b1);
        tick();
        m_reset0 = 1'b0;
        #1;
        check("clr_state", dbg_state, ST_IDLE);
        check("clr_busy", busy, 1'b0);
        check("clr_strobes", {m_src_getn0, m_dst_putn0, m_endn0}, 3'b111);
        cs = '0;
        for (int i = 0; i < put_cnt; i++) cs ^= ref_xf(2'b01, job_w[i]);
        check("clr_wcnt_kept", wcnt, CW'(put_cnt));
        check("clr_csum_kept", csum, cs);
        exp_wcnt = CW'(put_cnt);
        src_q.delete(); exp_q.delete(); refresh_flags();

        // start together with clear is dropped
        job_w = '{64'h55, 64'h66};
        load_job(2'b00, 1'b0);
        clear_stats();
        start = 1'b1; m_reset0 = 1'b1;
        tick();
        start = 1'b0; m_reset0 = 1'b0;
        repeat (2) tick();
        check("clr_start_busy", busy, 1'b0);
        check("clr_start_reads", rd_cnt, 0);
        check("clr_start_wcnt", wcnt, exp_wcnt);
        src_q.delete(); exp_q.delete(); refresh_flags();

        // randomized jobs with back-pressure and ignored starts
        drain_rand = 1;
        for (int j = 0; j < 25; j++) begin
            logic [1:0] o;
            logic ce;
            o = 2'($urandom_range(0, 3));
            ce = 1'($urandom_range(0, 1));
            job_w.delete();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) job_w.push_back({$urandom, $urandom});
            load_job(o, ce);
            launch(o, ce);
            wait_end(1);
            post_checks();
            check("rnd_reads", rd_cnt, n);
            check("rnd_src_empty", src_q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_copy.md
MOD_COPY -- requirements
Module: mod_copy

Interface
REQ-001 Parameter DW, default 64, data word width; all data ports use it.
REQ-002 Parameter CW, default 16, width of the word counter.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 wb_clk_i  in  1  sole clock.
REQ-005 wb_rst_i  in  1  asynchronous active-high reset.
REQ-006 m_reset0  in  1  synchronous job clear, same signal the channel FIFOs use.
REQ-007 start  in  1  one-cycle pulse that launches a job; ignored unless idle.
REQ-008 op  in  2  transform: 00 copy, 01 bitwise invert, 10 byte-swap within 64 bits, 11 copy.
REQ-009 csum_en  in  1  append an XOR checksum word after the data; sampled at start.
REQ-010 m_src_getn0  out  1  active-low read strobe to the source FIFO.
REQ-011 m_src0  in  DW  source data, valid the cycle after a read strobe.
REQ-012 m_src_last0  in  1  last-of-job flag accompanying m_src0.
REQ-013 m_src_almost_empty0, m_src_empty0  in  1 each  source FIFO level flags.
REQ-014 m_dst_putn0  out  1  active-low write strobe to the destination FIFO.
REQ-015 m_dst0  out  DW  destination data.
REQ-016 m_dst_last0  out  1  marks the final destination word of the job.
REQ-017 m_dst_almost_full0, m_dst_full0  in  1 each  destination FIFO level flags.
REQ-018 m_endn0  out  1  active-low one-cycle pulse: job output complete, flush downstream.
REQ-019 busy  out  1  job in progress; done  out  1  one-cycle completion pulse.
REQ-020 wcnt  out  CW  source words consumed in the current/last job; csum  out  DW  running XOR of transformed words.

Function
REQ-021 The FSM SHALL have states IDLE, RUN, CSUM, END.
REQ-022 IDLE->RUN on start; op and csum_en are latched there; wcnt and csum are cleared there.
REQ-023 rd_vld is a register equal to the previous cycle's read strobe (one-cycle read latency).
REQ-024 In RUN a read issues (getn low) when: !m_src_empty0, !m_dst_almost_full0, (!rd_vld or !m_src_almost_empty0), and !(rd_vld and m_src_last0), and no last has been fetched yet.
REQ-025 With those conditions, back-to-back reads SHALL sustain one word per cycle.
REQ-026 Each cycle with rd_vld, m_dst_putn0 SHALL be low with m_dst0 = transform(m_src0), wcnt += 1 (wrapping modulo 2^CW), and csum ^= transform(m_src0).
REQ-027 m_dst_last0 = m_src_last0 on that write when csum_en = 0, else 0.
REQ-028 On rd_vld and m_src_last0: next state is CSUM if csum_en, else END.
REQ-029 CSUM: write csum (including the final data word) with m_dst_last0 = 1 in the first cycle where !m_dst_full0, then go to END; hold while full.
REQ-030 END: m_endn0 low and done high for exactly one cycle, then IDLE; busy = (state != IDLE).
REQ-031 No write SHALL ever occur while m_dst_full0 = 1; the almost_full gate on reads guarantees room for the in-flight word.
REQ-032 start while busy SHALL be ignored; start coincident with m_reset0: m_reset0 wins.
REQ-033 m_reset0 mid-job SHALL force IDLE next cycle, drop any in-flight word (no putn), clear rd_vld, and deassert all strobes; wcnt/csum are retained until the next start.

Reset
REQ-034 On wb_rst_i: state IDLE, rd_vld 0, m_src_getn0 1, m_dst_putn0 1, m_endn0 1, m_dst_last0 0, m_dst0 0, busy 0, done 0, wcnt 0, csum 0, latched op/csum_en 0.

Structure
REQ-035 Shared package holds the FSM state encoding, the op code constants, and the DW/CW defaults.
REQ-036 One sub-module, mod_copy_xform (combinational op transform), is natural; the rest stays flat.

Verification
REQ-037 Copy 4 words 1,2,3,4 (last on 4), csum_en=0, FIFOs open -> 4 consecutive putn cycles, last on word 4, wcnt=4, m_endn0 pulse 1 cycle after the last putn.
REQ-038 Same data, op=01, csum_en=1 -> outputs ~1..~4 (none marked last), then a 5th word = ~1^~2^~3^~4 with last=1.
REQ-039 Hold m_dst_almost_full0 high for 3 cycles mid-job -> reads pause, no word lost or duplicated, order preserved.
REQ-040 A source holding a 2-word job followed by a second job's first word -> exactly 2 reads; the next word stays in the FIFO.
REQ-041 Assert m_reset0 while rd_vld=1 -> no putn follows, IDLE next cycle, all strobes high.
REQ-042 op=10 on 0x0102030405060708 -> 0x0807060504030201.
